// File: rtl/adder_share_arbiter.sv
// Two-client arbiter around a single 5-bit ripple adder: round-robin grant,
// operand capture at grant, registered per-client sum with one-cycle ack pulse.
module adder_share_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [4:0]       a_x,
  input  logic [4:0]       a_y,
  output logic             ack_a,
  output logic [5:0]       sum_a,
  input  logic             req_b,
  input  logic [4:0]       b_x,
  input  logic [4:0]       b_y,
  output logic             ack_b,
  output logic [5:0]       sum_b,
  output logic             busy,
  output logic             gnt,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t     state;
  logic       ptr;
  logic       win_b;
  logic [4:0] op_x;
  logic [4:0] op_y;
  logic [5:0] add_sum;

  function automatic logic [5:0] ripple_add(input logic [4:0] x, input logic [4:0] y);
    logic       c;
    logic [5:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 5; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    s[5] = c;
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // B wins when it is the only requester, or both request and the pointer names B.
  always_comb begin
    win_b   = req_b & (~req_a | ptr);
    add_sum = ripple_add(op_x, op_y);
  end

  // Operand capture at the grant edge; data path carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && (req_a || req_b)) begin
      op_x <= win_b ? b_x : a_x;
      op_y <= win_b ? b_y : a_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      sum_a    <= '0;
      sum_b    <= '0;
      busy     <= 1'b0;
      gnt      <= 1'b0;
      op_count <= '0;
      ptr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            gnt   <= win_b;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          if (gnt) begin
            sum_b <= add_sum;
            ack_b <= 1'b1;
          end else begin
            sum_a <= add_sum;
            ack_a <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          ack_a    <= 1'b0;
          ack_b    <= 1'b0;
          op_count <= sat_inc(op_count);
          ptr      <= ~gnt;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench: stimulus queues expected (client, sum) per transaction,
// a negedge monitor pops on every ack and checks sums, order and op counters.
module tb_adder_share_arbiter;

  typedef struct {
    logic       side;
    logic [5:0] sum;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [4:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
  logic       ack_a, ack_b, busy, gnt;
  logic [5:0] sum_a, sum_b;
  logic [7:0] op_count;
  logic       ack_a2, ack_b2, busy2, gnt2;
  logic [5:0] sum_a2, sum_b2;
  logic [1:0] op_count2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  adder_share_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a_x(a_x), .a_y(a_y), .ack_a(ack_a), .sum_a(sum_a),
    .req_b(req_b), .b_x(b_x), .b_y(b_y), .ack_b(ack_b), .sum_b(sum_b),
    .busy(busy), .gnt(gnt), .op_count(op_count)
  );

  adder_share_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a_x(a_x), .a_y(a_y), .ack_a(ack_a2), .sum_a(sum_a2),
    .req_b(req_b), .b_x(b_x), .b_y(b_y), .ack_b(ack_b2), .sum_b(sum_b2),
    .busy(busy2), .gnt(gnt2), .op_count(op_count2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference model of both sums and the op counters.
  logic [5:0] m_a = '0, m_b = '0;
  int         cnt_m = 0;
  logic       pend = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_a   = '0;
      m_b   = '0;
      cnt_m = 0;
      pend  = 1'b0;
    end else begin
      if (pend) begin
        chk("op_count", op_count, (cnt_m > 255) ? 255 : cnt_m);
        chk("op_count_sat", op_count2, (cnt_m > 3) ? 3 : cnt_m);
        pend = 1'b0;
      end
      if (ack_a && ack_b) chk("both_acks", 1, 0);
      if (ack_a || ack_b) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack_b, ack_a}, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_side", ack_b, e.side);
          if (e.side) m_b = e.sum;
          else        m_a = e.sum;
          cnt_m++;
          pend = 1'b1;
        end
        chk("sum_a", sum_a, m_a);
        chk("sum_b", sum_b, m_b);
      end
    end
  end

  function automatic exp_t mk(input logic side, input int s);
    exp_t e;
    e.side = side;
    e.sum  = 6'(s);
    return e;
  endfunction

  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (ack_a || ack_b) seen++;
    end
    if (seen < n) chk("ack_timeout", seen, n);
  endtask

  task automatic do_a(input logic [4:0] x, input logic [4:0] y);
    req_a = 1'b1; a_x = x; a_y = y;
    sb.push_back(mk(1'b0, int'(x) + int'(y)));
    wait_acks(1, 20);
    req_a = 1'b0;
  endtask

  task automatic do_b(input logic [4:0] x, input logic [4:0] y);
    req_b = 1'b1; b_x = x; b_y = y;
    sb.push_back(mk(1'b1, int'(x) + int'(y)));
    wait_acks(1, 20);
    req_b = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", {ack_a, ack_b}, 0);
    chk("rst_sum_a", sum_a, 0);
    chk("rst_sum_b", sum_b, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // Test 1: lone A request at the largest operands, latency and grant.
    req_a = 1'b1; a_x = 5'd31; a_y = 5'd31;
    sb.push_back(mk(1'b0, 62));
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("t1_busy", busy, 1);
        chk("t1_gnt", gnt, 0);
      end
      if (ack_a) break;
    end
    chk("t1_latency", lat, 2);
    req_a = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", ack_a, 0);

    // Test 2: lone B request; sum_a must keep 62.
    do_b(5'd10, 5'd7);
    chk("t2_ack_a", ack_a, 0);

    // Test 3: both requesting from reset, strict alternation A,B,A,B.
    rst = 1'b1;
    sb.delete();
    req_a = 1'b1; a_x = 5'd1; a_y = 5'd2;
    req_b = 1'b1; b_x = 5'd3; b_y = 5'd4;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b0, 3));
      sb.push_back(mk(1'b1, 7));
    end
    wait_acks(4, 30);
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    chk("t3_op_count", op_count, 4);

    // Test 4: operand change after grant does not affect the result.
    req_a = 1'b1; a_x = 5'd4; a_y = 5'd4;
    sb.push_back(mk(1'b0, 8));
    @(negedge clk);
    chk("t4_busy", busy, 1);
    a_x = 5'd20;
    wait_acks(1, 20);
    req_a = 1'b0;
    @(negedge clk);

    // Test 5: reset during B's ADD discards it; A wins afterwards.
    req_b = 1'b1; b_x = 5'd9; b_y = 5'd9;
    @(negedge clk);
    chk("t5_busy", busy, 1);
    chk("t5_gnt", gnt, 1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t5_async_busy", busy, 0);
    req_b = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_ack_b", ack_b, 0);
    req_a = 1'b1; a_x = 5'd1; a_y = 5'd1;
    req_b = 1'b1; b_x = 5'd2; b_y = 5'd2;
    sb.push_back(mk(1'b0, 2));
    sb.push_back(mk(1'b1, 4));
    @(negedge clk);
    chk("t5_gnt_after", gnt, 0);
    wait_acks(2, 20);
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);

    // Test 6: five more A ops; the 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      do_a(5'(i), 5'd1);
      @(negedge clk);
    end
    chk("t6_op_count", op_count, 7);
    chk("t6_op_count_sat", op_count2, 3);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
